// File: rtl/drum_audio_tx_pkg.sv
// Shared types and default widths for the drum audio transmit path.
// Holds the transmit FSM state enum imported by drum_audio_tx.
package drum_pkg;

  localparam int DATA_W_DEF     = 18;
  localparam int AUDIO_W_DEF    = 32;
  localparam int SHIFT_DEF      = 14;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_LEFT,
    S_RIGHT
  } tx_state_t;

endpackage

// File: rtl/drum_audio_tx_if.sv
// Codec-side sample bus: one shared data word, left/right valid/ready.
// master = transmitter (drives data/valids), slave = audio core.
interface drum_audio_tx_if #(
  parameter int AUDIO_W = 32
);
  logic [AUDIO_W-1:0] audio_data;
  logic               audio_left_valid;
  logic               audio_left_ready;
  logic               audio_right_valid;
  logic               audio_right_ready;

  modport master (
    output audio_data,
    output audio_left_valid,
    output audio_right_valid,
    input  audio_left_ready,
    input  audio_right_ready
  );

  modport slave (
    input  audio_data,
    input  audio_left_valid,
    input  audio_right_valid,
    output audio_left_ready,
    output audio_right_ready
  );
endinterface

// File: rtl/drum_audio_tx_fifo.sv
// drum_sample_fifo: sync FIFO, registered full/empty, level output.
// Ports: clk, rst, push/wdata, pop/rdata (head), full, empty, level.
module drum_sample_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [LW-1:0] lvl_nxt;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  assign lvl_nxt = level + LW'(do_push)
                 - LW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are AW bits wide, so they wrap
  // modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= lvl_nxt;
      full  <= (lvl_nxt == LW'(DEPTH));
      empty <= (lvl_nxt == '0);
    end
  end

endmodule

// File: rtl/drum_audio_tx.sv
// Drains solver node samples to the codec as left/right word pairs.
// Ports: clk, rst, sample_in/valid/ready, audio (if master),
// fifo_level, overflow. Option: DRUM_TX_HOLD_EN (re-send on stall).
module drum_audio_tx
  import drum_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int AUDIO_W    = AUDIO_W_DEF,
  parameter int SHIFT      = SHIFT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  drum_audio_tx_if.master   audio,
  output logic [LW-1:0]     fifo_level,
  output logic              overflow
);

  tx_state_t         state;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic [AUDIO_W-1:0] scaled;

  // Ready comes straight from the registered full
  // flag, so a same-cycle pop never frees a slot.
  assign sample_ready = ~full;
  assign push         = sample_valid & sample_ready;
  assign pop          = (state == S_POP);

  assign scaled = {{(AUDIO_W-DATA_W){head[DATA_W-1]}},
                   head} << SHIFT;

  drum_sample_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (sample_in),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (sample_valid & ~sample_ready)
      overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= S_IDLE;
      audio.audio_data        <= '0;
      audio.audio_left_valid  <= 1'b0;
      audio.audio_right_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            state <= S_POP;
`ifdef DRUM_TX_HOLD_EN
          end else if (audio.audio_left_ready) begin
            // Replay the last word to keep codec rate.
            state                  <= S_LEFT;
            audio.audio_left_valid <= 1'b1;
`endif
          end
        end
        S_POP: begin
          audio.audio_data       <= scaled;
          audio.audio_left_valid <= 1'b1;
          state                  <= S_LEFT;
        end
        S_LEFT: begin
          if (audio.audio_left_ready) begin
            audio.audio_left_valid  <= 1'b0;
            audio.audio_right_valid <= 1'b1;
            state                   <= S_RIGHT;
          end
        end
        S_RIGHT: begin
          if (audio.audio_right_ready) begin
            audio.audio_right_valid <= 1'b0;
            state <= empty ? S_IDLE : S_POP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
